// File: rtl/i2s_tdm_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// i2s_tdm_frame_sequencer : lrclk lock, frame-length check, per-slot strobes.
// Optional `SLOT_MASK_EN adds a per-frame slot_mask input.     Rev 1.0
// ----------------------------------------------------------------------------
module i2s_tdm_frame_sequencer #(
    parameter int SLOT_WIDTH   = 32,
    parameter int SAMPLE_WIDTH = 24,
    parameter int NUM_SLOTS    = 24,
    parameter int LOCK_FRAMES  = 2,
    parameter int DATA_DELAY   = 1,
    localparam int C_IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                    i2s_bclk,
    input  logic                    sys_rst,
    input  logic                    i2s_lrclk,
    input  logic                    i2s_data,
`ifdef SLOT_MASK_EN
    input  logic [NUM_SLOTS-1:0]    slot_mask,
`endif
    output logic [SAMPLE_WIDTH-1:0] slot_data,
    output logic [C_IDX_W-1:0]      slot_idx,
    output logic                    slot_strobe,
    output logic                    frame_start,
    output logic                    locked,
    output logic                    frame_err,
    output logic [15:0]             err_count
);

    localparam int c_frame_bits = SLOT_WIDTH * NUM_SLOTS;
    localparam int c_cnt_w      = $clog2(c_frame_bits + 1);
    localparam int c_good_w     = $clog2(LOCK_FRAMES + 1);
    localparam logic [c_cnt_w-1:0]  c_last_bit    = c_cnt_w'(c_frame_bits - 1);
    localparam logic [c_cnt_w-1:0]  c_sample_w    = c_cnt_w'(SAMPLE_WIDTH);
    localparam logic [c_cnt_w-1:0]  c_sample_last = c_cnt_w'(SAMPLE_WIDTH - 1);
    localparam logic [c_good_w-1:0] c_lock_last   = c_good_w'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_prev_lrclk;
    logic [c_cnt_w-1:0]      r_bit_cnt;
    logic [c_good_w-1:0]     r_good_cnt;
    logic [SAMPLE_WIDTH-1:0] r_shift;

    logic                    w_edge;
    logic                    w_data_d;
    logic                    w_frame_end;
    logic                    w_mask_bit;
    logic                    w_deliver;
    logic [c_cnt_w-1:0]      w_pos;
    logic [c_cnt_w-1:0]      w_sbit;
    logic [C_IDX_W-1:0]      w_slot;
    logic [SAMPLE_WIDTH-1:0] w_shift_next;

    generate
        if (DATA_DELAY == 0) begin : g_no_delay
            assign w_data_d = i2s_data;
        end else begin : g_delay
            logic [DATA_DELAY-1:0] r_dly;
            always_ff @(posedge i2s_bclk or posedge sys_rst) begin
                if (sys_rst) begin
                    r_dly <= '0;
                end else begin
                    r_dly <= (r_dly << 1) | DATA_DELAY'(i2s_data);
                end
            end
            assign w_data_d = r_dly[DATA_DELAY-1];
        end
    endgenerate

    // w_pos is the frame bit index of the current cycle; r_bit_cnt holds the previous one.
    assign w_edge       = i2s_lrclk & ~r_prev_lrclk;
    assign w_pos        = w_edge ? '0 : r_bit_cnt + 1'b1;
    assign w_sbit       = c_cnt_w'(w_pos % SLOT_WIDTH);
    assign w_slot       = C_IDX_W'(w_pos / SLOT_WIDTH);
    assign w_frame_end  = (r_bit_cnt == c_last_bit);
    assign w_shift_next = (r_shift << 1) | SAMPLE_WIDTH'(w_data_d);

`ifdef SLOT_MASK_EN
    logic [NUM_SLOTS-1:0] r_mask;
    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_mask <= '0;
        end else if (w_edge) begin
            r_mask <= slot_mask;
        end
    end
    assign w_mask_bit = r_mask[w_slot];
`else
    assign w_mask_bit = 1'b1;
`endif

    // Edge and frame-end cycles never complete a slot, so an aborted frame never strobes.
    assign w_deliver = (r_state == ST_LOCKED) && !w_edge && !w_frame_end
                       && (w_sbit == c_sample_last) && w_mask_bit;

    always_ff @(posedge i2s_bclk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state      <= ST_HUNT;
            r_prev_lrclk <= 1'b0;
            r_bit_cnt    <= '0;
            r_good_cnt   <= '0;
            r_shift      <= '0;
            slot_data    <= '0;
            slot_idx     <= '0;
            slot_strobe  <= 1'b0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            frame_err    <= 1'b0;
            err_count    <= '0;
        end else begin
            r_prev_lrclk <= i2s_lrclk;
            r_bit_cnt    <= w_pos;
            slot_strobe  <= 1'b0;
            frame_start  <= 1'b0;
            frame_err    <= 1'b0;

            if (w_sbit < c_sample_w) begin
                r_shift <= w_shift_next;
            end
            if (w_deliver) begin
                slot_strobe <= 1'b1;
                slot_idx    <= w_slot;
                slot_data   <= w_shift_next;
            end

            case (r_state)
                ST_HUNT: begin
                    if (w_edge) begin
                        r_state    <= ST_CHECK;
                        r_good_cnt <= '0;
                    end
                end
                ST_CHECK, ST_LOCKED: begin
                    if (w_edge && w_frame_end) begin
                        if (r_state == ST_LOCKED) begin
                            frame_start <= 1'b1;
                        end else if (r_good_cnt == c_lock_last) begin
                            r_state     <= ST_LOCKED;
                            locked      <= 1'b1;
                            frame_start <= 1'b1;
                        end else begin
                            r_good_cnt <= r_good_cnt + 1'b1;
                        end
                    end else if (w_edge || w_frame_end) begin
                        // Early edge restarts checking from this edge; a missing edge loses sync.
                        frame_err  <= 1'b1;
                        locked     <= 1'b0;
                        r_good_cnt <= '0;
                        r_state    <= w_edge ? ST_CHECK : ST_HUNT;
                        if (err_count != 16'hFFFF) begin
                            err_count <= err_count + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_i2s_tdm_frame_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_i2s_tdm_frame_sequencer : directed frame scenarios, DATA_DELAY 1 and 0.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_i2s_tdm_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        lrclk;
    logic        d1;
    logic        d0;
    logic [23:0] mask_drv = 24'hFFFFFF;
    logic [23:0] mask_chg = 24'hFFFFFF;
    int          chg_n = -1;
    logic [23:0] base = 24'hA00000;

    logic [23:0] data1, data0;
    logic [4:0]  idx1, idx0;
    logic        strb1, strb0, fs1, fs0, lk1, lk0, fe1, fe0;
    logic [15:0] ec1, ec0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    i2s_tdm_frame_sequencer #(.DATA_DELAY(1)) u_dut1 (
        .i2s_bclk   (clk),
        .sys_rst    (rst),
        .i2s_lrclk  (lrclk),
        .i2s_data   (d1),
`ifdef SLOT_MASK_EN
        .slot_mask  (mask_drv),
`endif
        .slot_data  (data1),
        .slot_idx   (idx1),
        .slot_strobe(strb1),
        .frame_start(fs1),
        .locked     (lk1),
        .frame_err  (fe1),
        .err_count  (ec1)
    );

    i2s_tdm_frame_sequencer #(.DATA_DELAY(0)) u_dut0 (
        .i2s_bclk   (clk),
        .sys_rst    (rst),
        .i2s_lrclk  (lrclk),
        .i2s_data   (d0),
`ifdef SLOT_MASK_EN
        .slot_mask  (mask_drv),
`endif
        .slot_data  (data0),
        .slot_idx   (idx0),
        .slot_strobe(strb0),
        .frame_start(fs0),
        .locked     (lk0),
        .frame_err  (fe0),
        .err_count  (ec0)
    );

    // Wire bit n of a frame: 24-bit sample MSB-first, 8 pad bits of 1.
    function automatic logic fbit(input int n_in, input int len);
        int n;
        int slot;
        int sb;
        logic [23:0] s;
        n = n_in;
        if (n >= len) n = n - len;
        slot = n / 32;
        sb   = n % 32;
        if (slot >= 24) return 1'b0;
        s = base + 24'(slot);
        if (sb < 24) return s[23-sb];
        return 1'b1;
    endfunction

    task automatic step(input logic lr, input logic b0, input logic b1);
        lrclk = lr;
        d0    = b0;
        d1    = b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cyc, input logic lr);
        for (int i = 0; i < cyc; i++) step(lr, fbit(0, 768), fbit(0, 768));
    endtask

    // One frame; the DATA_DELAY=1 instance gets the same stream one bclk earlier.
    task automatic run_frame(input int len, input int ncyc, input bit hold_hi,
                             input bit e_strb, input bit e_fs, input bit e_err, input bit e_lock);
        logic [23:0] fmask;
        fmask = mask_drv;
        for (int n = 0; n < ncyc; n++) begin
            logic        exp_s;
            int          k;
            logic [23:0] exp_d;
            if (n == chg_n) mask_drv = mask_chg;
            step(hold_hi ? 1'b1 : logic'(n < len / 2), fbit(n, len), fbit(n + 1, len));
            k     = n / 32;
            exp_s = e_strb && (n % 32 == 23) && (k < 24) && (n < len) && fmask[k];
            exp_d = base + 24'(k);
            checks++;
            if (strb1 !== exp_s) begin
                errors++;
                $display("FAIL strobe_dd1 n=%0d got=%b want=%b", n, strb1, exp_s);
            end
            checks++;
            if (strb0 !== exp_s) begin
                errors++;
                $display("FAIL strobe_dd0 n=%0d got=%b want=%b", n, strb0, exp_s);
            end
            if (exp_s) begin
                checks++;
                if (idx1 !== 5'(k) || data1 !== exp_d) begin
                    errors++;
                    $display("FAIL slot_dd1 n=%0d got idx=%0d data=%h want idx=%0d data=%h",
                             n, idx1, data1, k, exp_d);
                end
                checks++;
                if (idx0 !== 5'(k) || data0 !== exp_d) begin
                    errors++;
                    $display("FAIL slot_dd0 n=%0d got idx=%0d data=%h want idx=%0d data=%h",
                             n, idx0, data0, k, exp_d);
                end
            end
            checks++;
            if (fs1 !== (e_fs && n == 0)) begin
                errors++;
                $display("FAIL frame_start n=%0d got=%b want=%b", n, fs1, e_fs && n == 0);
            end
            checks++;
            if (fe1 !== (e_err && n == 0)) begin
                errors++;
                $display("FAIL frame_err n=%0d got=%b want=%b", n, fe1, e_err && n == 0);
            end
            checks++;
            if (lk1 !== e_lock || lk0 !== e_lock) begin
                errors++;
                $display("FAIL locked n=%0d got=%b/%b want=%b", n, lk1, lk0, e_lock);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(4, 1'b0);
        checks++;
        if ({data1, idx1, strb1, fs1, lk1, fe1} !== '0 || ec1 !== 16'h0) begin
            errors++;
            $display("FAIL reset_dd1 got data=%h idx=%0d s=%b fs=%b lk=%b fe=%b ec=%0d want all 0",
                     data1, idx1, strb1, fs1, lk1, fe1, ec1);
        end
        checks++;
        if ({data0, idx0, strb0, fs0, lk0, fe0} !== '0 || ec0 !== 16'h0) begin
            errors++;
            $display("FAIL reset_dd0 got data=%h idx=%0d s=%b fs=%b lk=%b fe=%b ec=%0d want all 0",
                     data0, idx0, strb0, fs0, lk0, fe0, ec0);
        end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        idle(4, 1'b0);
        run_frame(768, 768, 0, 0, 0, 0, 0);
        run_frame(768, 768, 0, 0, 0, 0, 0);
        run_frame(768, 768, 0, 1, 1, 0, 1);
        run_frame(768, 768, 0, 1, 1, 0, 1);
        checks++;
        if (ec1 !== 16'd0) begin
            errors++;
            $display("FAIL lock_err_count got=%0d want=0", ec1);
        end
    endtask

    task automatic test_short_frame();
        run_frame(701, 701, 0, 1, 1, 0, 1);
        run_frame(768, 768, 0, 0, 0, 1, 0);
        checks++;
        if (ec1 !== 16'd1 || ec0 !== 16'd1) begin
            errors++;
            $display("FAIL short_err_count got=%0d/%0d want=1", ec1, ec0);
        end
        run_frame(768, 768, 0, 0, 0, 0, 0);
        run_frame(768, 768, 0, 1, 1, 0, 1);
    endtask

    task automatic test_pattern();
        base = 24'hC3C300;
        run_frame(768, 768, 0, 1, 1, 0, 1);
        base = 24'hA00000;
        run_frame(768, 768, 0, 1, 1, 0, 1);
    endtask

    task automatic test_missing_edge();
        run_frame(768, 768, 1, 1, 1, 0, 1);
        run_frame(768, 768, 1, 0, 0, 1, 0);
        idle(1, 1'b0);
        run_frame(768, 768, 0, 0, 0, 0, 0);
        checks++;
        if (ec1 !== 16'd2) begin
            errors++;
            $display("FAIL missing_err_count got=%0d want=2", ec1);
        end
    endtask

    task automatic test_reset_mid_frame();
        run_frame(768, 768, 0, 0, 0, 0, 0);
        run_frame(768, 768, 0, 1, 1, 0, 1);
        run_frame(768, 344, 0, 1, 1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({data1, idx1, strb1, fs1, lk1, fe1} !== '0 || ec1 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_dd1 got data=%h idx=%0d s=%b lk=%b ec=%0d want all 0",
                     data1, idx1, strb1, lk1, ec1);
        end
        checks++;
        if ({data0, idx0, strb0, fs0, lk0, fe0} !== '0 || ec0 !== 16'h0) begin
            errors++;
            $display("FAIL async_reset_dd0 got data=%h idx=%0d s=%b lk=%b ec=%0d want all 0",
                     data0, idx0, strb0, lk0, ec0);
        end
        idle(3, 1'b0);
        rst = 1'b0;
        idle(2, 1'b0);
        run_frame(768, 768, 0, 0, 0, 0, 0);
        run_frame(768, 768, 0, 0, 0, 0, 0);
        run_frame(768, 768, 0, 1, 1, 0, 1);
        checks++;
        if (ec1 !== 16'd0) begin
            errors++;
            $display("FAIL relock_err_count got=%0d want=0", ec1);
        end
    endtask

`ifdef SLOT_MASK_EN
    task automatic test_slot_mask();
        mask_drv = 24'h000005;
        run_frame(768, 768, 0, 1, 1, 0, 1);
        mask_chg = 24'h000010;
        chg_n    = 100;
        run_frame(768, 768, 0, 1, 1, 0, 1);
        chg_n    = -1;
        run_frame(768, 768, 0, 1, 1, 0, 1);
        mask_drv = 24'hFFFFFF;
        run_frame(768, 768, 0, 1, 1, 0, 1);
    endtask
`endif

    initial begin
        rst   = 1'b1;
        lrclk = 1'b0;
        d0    = 1'b0;
        d1    = 1'b0;
        test_reset();
        test_lock();
        test_short_frame();
        test_pattern();
        test_missing_edge();
        test_reset_mid_frame();
`ifdef SLOT_MASK_EN
        test_slot_mask();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
